exec_arith_branch_unit: RTL and testbench
=========================================

Name: exec_arith_branch_unit

Overview:
- Execute-stage slice of the pipeline: add/subtract (addx), absolute value (absx) and conditional branch resolution (branch).
- Arithmetic results and valid are registered on the output; condition flags live in an internal register.
- Branch decision is combinational from the flags register and drives the fetch-stage redirect.

Parameters:
- W_OPR, 32, operand/result width
- W_IMM, 16, immediate width
- ADDR, 16, PC/branch address width
- W_FLAGS, 4, flag bits: 0 carry C, 1 zero Z, 2 sign S, 3 overflow V
- W_CC, 4, condition-code width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- v_i  in  1  input instruction valid
- stall_i  in  1  pipeline stall; 1 holds all registers
- op_i  in  2  unit select: 0 addx, 1 absx, 2 branch, 3 nop
- sel_i  in  2  sub-operation select
- immf_i  in  1  use immediate instead of opr1_i
- sign_i  in  1  sign-extend immediate (else zero-extend)
- imm_i  in  W_IMM  immediate
- opr0_i  in  W_OPR  operand 0; [W_CC-1:0] is the branch condition code
- opr1_i  in  W_OPR  operand 1
- pc_i  in  ADDR  PC of the current instruction
- v_o  out  1  registered valid
- result_o  out  W_OPR  registered result
- flags_o  out  W_FLAGS  flags register
- stall_o  out  1  equals stall_i
- branch_o  out  1  branch taken (combinational)
- branch_addr_o  out  ADDR  branch target (combinational)

Behaviour:
- Second operand B = immf_i ? ext(imm_i) : opr1_i. ext = sign- or zero-extension to W_OPR per sign_i.
- addx (A = opr0_i):
  - sel 0: add, A+B.
  - sel 1: sub, A+~B+1.
  - sel 2: adc, A+B+C.
  - sel 3: sbb, A+~B+C.
  - C = carry-out of bit W_OPR-1. For sub, C=1 means no borrow.
  - V(add) = (A31==B31)&(R31!=A31).
  - V(sub) = (A31!=B31)&(R31!=A31).
  - Z = (R==0); S = R31.
- absx:
  - R = B31 ? -B : B. 0x80000000 stays 0x80000000.
  - V=1 only for that input. C=0. Z and S are taken from R.
- branch:
  - Target T = B[ADDR-1:0]. sel_i[0]=0 means absolute, branch_addr_o=T. sel_i[0]=1 means relative, pc_i+T, wrapping mod 2^ADDR.
  - branch_o = v_i & (op_i==2) & cond(cc, flags register).
  - cc values: 0 always; 1 eq Z; 2 ne !Z; 3 cs C; 4 cc !C; 5 mi S; 6 pl !S; 7 vs V; 8 vc !V; 9 hi C&!Z; 10 ls !C|Z; 11 ge S==V; 12 lt S!=V; 13 gt !Z&(S==V); 14 le Z|(S!=V); 15 never.
  - Branch uses flags committed by earlier instructions; there is no forwarding from the instruction currently in the stage.
  - branch_addr_o is always driven; it is meaningful only when branch_o=1.
- Registers, when stall_i=0, at posedge clk:
  - v_o <= v_i.
  - result_o <= selected result. Branch and nop produce 0.
  - flags <= new flags only if v_i & op_i in {0,1}; otherwise flags are held.
- Registers when stall_i=1: everything holds. branch_o is still evaluated combinationally.
- Latency: 1 cycle for result/flags. 0 cycles for branch.
- Reset (reset=0, async): v_o=0, result_o=0, flags=0. Mid-operation reset discards the in-flight instruction immediately.

Optional Feature:
- Macro ADDX_CARRY_EN.
- Defined: sel 2/3 perform adc/sbb as above.
- Undefined: sel 2 behaves as add, sel 3 as sub, and the carry-in is ignored.

Decomposition:
- Shared package holds:
  - Width constants W_OPR, W_IMM, ADDR, W_FLAGS, W_CC.
  - Flag bit indices FLAG_C/Z/S/V.
  - op_i encodings OP_ADDX/ABSX/BRANCH/NOP.
  - addx sel encodings.
  - The 16 cc encodings.
- One natural sub-module: exec_arith_branch_cond, a combinational cc + flags -> taken evaluator.

Test Plan:
- addx add: A=0x7FFFFFFF, B=1 -> result 0x80000000, flags V=1 S=1 Z=0 C=0 one cycle later.
- addx sub with immediate: A=5, imm=0xFFFB, sign=1, sel=0 (add) -> result 0, Z=1 C=1. Then sel=1 with A=3, B=5 -> result 0xFFFFFFFE, C=0 S=1.
- absx: B=0xFFFFFFF6 -> result 10, flags 0. B=0x80000000 -> result 0x80000000, V=1 S=1.
- branch: after a flag-setting op gives Z=1, issue op=2, cc=1, sel0=1, pc=0x0100, imm=0x0010 -> branch_o=1, branch_addr_o=0x0110. Same with cc=2 -> branch_o=0. Flags unchanged.
- Stall and invalid: stall_i=1 during an addx -> v_o, result_o and flags hold. v_i=0 addx -> flags hold, v_o=0. v_i=0 branch -> branch_o=0.
- Reset mid-stream: assert reset=0 asynchronously -> v_o=0, result_o=0, flags=0 without waiting for a clock edge.
- If ADDX_CARRY_EN is defined: C=1, adc with 1+1 -> result 3.

Source files
------------

// File: rtl/exec_arith_branch_unit_pkg.sv
// rtl/exec_arith_branch_unit_pkg.sv - shared widths, flag indices and encodings for the execute slice
package exec_arith_branch_unit_pkg;

    localparam int W_OPR   = 32;
    localparam int W_IMM   = 16;
    localparam int ADDR    = 16;
    localparam int W_FLAGS = 4;
    localparam int W_CC    = 4;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        OP_ADDX   = 2'd0,
        OP_ABSX   = 2'd1,
        OP_BRANCH = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_SUB = 2'd1,
        SEL_ADC = 2'd2,
        SEL_SBB = 2'd3
    } addx_sel_e;

    typedef enum logic [W_CC-1:0] {
        CC_AL = 4'd0,
        CC_EQ = 4'd1,
        CC_NE = 4'd2,
        CC_CS = 4'd3,
        CC_CC = 4'd4,
        CC_MI = 4'd5,
        CC_PL = 4'd6,
        CC_VS = 4'd7,
        CC_VC = 4'd8,
        CC_HI = 4'd9,
        CC_LS = 4'd10,
        CC_GE = 4'd11,
        CC_LT = 4'd12,
        CC_GT = 4'd13,
        CC_LE = 4'd14,
        CC_NV = 4'd15
    } cc_e;

endpackage

// File: rtl/exec_arith_branch_cond.sv
// rtl/exec_arith_branch_cond.sv - combinational condition-code evaluator over the flags register
module exec_arith_branch_cond
    import exec_arith_branch_unit_pkg::*;
(
    input  logic [W_CC-1:0]    cc,
    input  logic [W_FLAGS-1:0] flags,
    output logic               taken
);

    logic c, z, s, v;

    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign s = flags[FLAG_S];
    assign v = flags[FLAG_V];

    // Decode the condition code against the committed flags
    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_AL: taken = 1'b1;
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_MI: taken = s;
            CC_PL: taken = !s;
            CC_VS: taken = v;
            CC_VC: taken = !v;
            CC_HI: taken = c && !z;
            CC_LS: taken = !c || z;
            CC_GE: taken = (s == v);
            CC_LT: taken = (s != v);
            CC_GT: taken = !z && (s == v);
            CC_LE: taken = z || (s != v);
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_arith_branch_unit.sv
// rtl/exec_arith_branch_unit.sv - execute stage addx/absx/branch slice; ADDX_CARRY_EN enables adc/sbb
module exec_arith_branch_unit
    import exec_arith_branch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               v_i,
    input  logic               stall_i,
    input  logic [1:0]         op_i,
    input  logic [1:0]         sel_i,
    input  logic               immf_i,
    input  logic               sign_i,
    input  logic [W_IMM-1:0]   imm_i,
    input  logic [W_OPR-1:0]   opr0_i,
    input  logic [W_OPR-1:0]   opr1_i,
    input  logic [ADDR-1:0]    pc_i,
    output logic               v_o,
    output logic [W_OPR-1:0]   result_o,
    output logic [W_FLAGS-1:0] flags_o,
    output logic               stall_o,
    output logic               branch_o,
    output logic [ADDR-1:0]    branch_addr_o
);

    localparam logic [W_OPR-1:0] MIN_NEG = {1'b1, {(W_OPR-1){1'b0}}};

    logic [W_OPR-1:0]   a, b, b_ext, b_op, add_r, abs_r, res_d;
    logic [W_OPR:0]     sum;
    logic               is_sub, carry_in, add_v;
    logic [W_FLAGS-1:0] flags_q, flags_d;
    logic               cond_taken;
    logic [ADDR-1:0]    target;

    assign a     = opr0_i;
    assign b_ext = sign_i ? {{(W_OPR-W_IMM){imm_i[W_IMM-1]}}, imm_i}
                          : {{(W_OPR-W_IMM){1'b0}}, imm_i};
    assign b     = immf_i ? b_ext : opr1_i;

    // Carry-in per sub-op; without the carry feature adc/sbb fold onto add/sub
    always_comb begin
        is_sub   = 1'b0;
        carry_in = 1'b0;
        case (sel_i)
            SEL_ADD: begin is_sub = 1'b0; carry_in = 1'b0; end
            SEL_SUB: begin is_sub = 1'b1; carry_in = 1'b1; end
`ifdef ADDX_CARRY_EN
            SEL_ADC: begin is_sub = 1'b0; carry_in = flags_q[FLAG_C]; end
            SEL_SBB: begin is_sub = 1'b1; carry_in = flags_q[FLAG_C]; end
`else
            SEL_ADC: begin is_sub = 1'b0; carry_in = 1'b0; end
            SEL_SBB: begin is_sub = 1'b1; carry_in = 1'b1; end
`endif
            default: begin is_sub = 1'b0; carry_in = 1'b0; end
        endcase
    end

    assign b_op  = is_sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_op} + {{W_OPR{1'b0}}, carry_in};
    assign add_r = sum[W_OPR-1:0];
    assign add_v = is_sub ? ((a[W_OPR-1] != b[W_OPR-1]) && (add_r[W_OPR-1] != a[W_OPR-1]))
                          : ((a[W_OPR-1] == b[W_OPR-1]) && (add_r[W_OPR-1] != a[W_OPR-1]));

    // Negating the most negative value wraps back to itself, which is the intended result
    assign abs_r = b[W_OPR-1] ? (~b + W_OPR'(1)) : b;

    // Select the stage result and the flags it would commit
    always_comb begin
        res_d   = '0;
        flags_d = flags_q;
        case (op_i)
            OP_ADDX: begin
                res_d           = add_r;
                flags_d[FLAG_C] = sum[W_OPR];
                flags_d[FLAG_Z] = (add_r == '0);
                flags_d[FLAG_S] = add_r[W_OPR-1];
                flags_d[FLAG_V] = add_v;
            end
            OP_ABSX: begin
                res_d           = abs_r;
                flags_d[FLAG_C] = 1'b0;
                flags_d[FLAG_Z] = (abs_r == '0);
                flags_d[FLAG_S] = abs_r[W_OPR-1];
                flags_d[FLAG_V] = (b == MIN_NEG);
            end
            default: begin
                res_d   = '0;
                flags_d = flags_q;
            end
        endcase
    end

    // Output and flag registers; stall freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_o      <= 1'b0;
            result_o <= '0;
            flags_q  <= '0;
        end else if (!stall_i) begin
            v_o      <= v_i;
            result_o <= res_d;
            if (v_i && (op_i == OP_ADDX || op_i == OP_ABSX)) begin
                flags_q <= flags_d;
            end
        end
    end

    exec_arith_branch_cond u_cond (
        .cc    (opr0_i[W_CC-1:0]),
        .flags (flags_q),
        .taken (cond_taken)
    );

    assign target        = b[ADDR-1:0];
    assign branch_addr_o = sel_i[0] ? (pc_i + target) : target;
    assign branch_o      = v_i && (op_i == OP_BRANCH) && cond_taken;
    assign flags_o       = flags_q;
    assign stall_o       = stall_i;

endmodule

// File: tb/tb_exec_arith_branch_unit.sv
// tb/tb_exec_arith_branch_unit.sv - randomized and directed bench with a behavioural reference model
module tb_exec_arith_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_i = 1'b0, stall_i = 1'b0, immf_i = 1'b0, sign_i = 1'b0;
    logic [1:0]  op_i = 2'd3, sel_i = 2'd0;
    logic [15:0] imm_i = '0, pc_i = '0;
    logic [31:0] opr0_i = '0, opr1_i = '0;
    logic        v_o, stall_o, branch_o;
    logic [31:0] result_o;
    logic [3:0]  flags_o;
    logic [15:0] branch_addr_o;

    exec_arith_branch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .v_i           (v_i),
        .stall_i       (stall_i),
        .op_i          (op_i),
        .sel_i         (sel_i),
        .immf_i        (immf_i),
        .sign_i        (sign_i),
        .imm_i         (imm_i),
        .opr0_i        (opr0_i),
        .opr1_i        (opr1_i),
        .pc_i          (pc_i),
        .v_o           (v_o),
        .result_o      (result_o),
        .flags_o       (flags_o),
        .stall_o       (stall_o),
        .branch_o      (branch_o),
        .branch_addr_o (branch_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_v = 1'b0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_flags = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bval();
        if (!immf_i) return opr1_i;
        if (sign_i) return 32'($signed(imm_i));
        return {16'h0, imm_i};
    endfunction

    // Condition table with flags named as C=bit0 Z=bit1 S=bit2 V=bit3
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic c, z, s, v;
        c = f[0]; z = f[1]; s = f[2]; v = f[3];
        case (cc)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return c;
            4'd4:  return !c;
            4'd5:  return s;
            4'd6:  return !s;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return c && !z;
            4'd10: return !c || z;
            4'd11: return s == v;
            4'd12: return s != v;
            4'd13: return !z && (s == v);
            4'd14: return z || (s != v);
            default: return 1'b0;
        endcase
    endfunction

    // Outputs are compared mid-cycle, well away from the rising edge
    task automatic check_now();
        logic [31:0] b;
        logic [15:0] exp_addr;
        logic        exp_br;
        b        = bval();
        exp_addr = sel_i[0] ? 16'(pc_i + b[15:0]) : b[15:0];
        exp_br   = v_i && (op_i == 2'd2) && cond_ok(opr0_i[3:0], m_flags);
        chk("v_o", {31'b0, v_o}, {31'b0, m_v});
        chk("result_o", result_o, m_res);
        chk("flags_o", {28'b0, flags_o}, {28'b0, m_flags});
        chk("stall_o", {31'b0, stall_o}, {31'b0, stall_i});
        chk("branch_o", {31'b0, branch_o}, {31'b0, exp_br});
        chk("branch_addr_o", {16'b0, branch_addr_o}, {16'b0, exp_addr});
    endtask

    // Arithmetic computed with wide signed/unsigned integers rather than bit formulas
    task automatic advance();
        logic [31:0] a, b, bop, r;
        logic [3:0]  f;
        longint      u, s;
        int          cin;
        logic        sub;
        a = opr0_i;
        b = bval();
        r = '0;
        f = m_flags;
        if (op_i == 2'd0) begin
            sub = sel_i[0];
`ifdef ADDX_CARRY_EN
            cin = sel_i[1] ? int'(m_flags[0]) : int'(sub);
`else
            cin = int'(sub);
`endif
            bop = sub ? ~b : b;
            u = longint'(a) + longint'(bop) + longint'(cin);
            s = longint'($signed(a)) + longint'($signed(bop)) + longint'(cin);
            r = u[31:0];
            f = {(s > 64'sd2147483647 || s < -64'sd2147483648), r[31], (r == 0), u[32]};
        end else if (op_i == 2'd1) begin
            if (b == 32'h8000_0000) r = b;
            else if ($signed(b) < 0) r = 32'(-$signed(b));
            else r = b;
            f = {(b == 32'h8000_0000), r[31], (r == 0), 1'b0};
        end
        if (!stall_i) begin
            m_v   = v_i;
            m_res = (op_i < 2'd2) ? r : 32'h0;
            if (v_i && op_i < 2'd2) m_flags = f;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        #3;
        check_now();
        advance();
    endtask

    task automatic set(input logic v, input logic st, input logic [1:0] op, input logic [1:0] sel,
                       input logic immf, input logic sg, input logic [15:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc);
        v_i = v; stall_i = st; op_i = op; sel_i = sel; immf_i = immf; sign_i = sg;
        imm_i = imm; opr0_i = a; opr1_i = b; pc_i = pc;
    endtask

    initial begin
        #12;
        chk("reset_v", {31'b0, v_o}, 32'h0);
        chk("reset_result", result_o, 32'h0);
        chk("reset_flags", {28'b0, flags_o}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        set(1, 0, 2'd0, 2'd0, 0, 0, 16'h0, 32'h7FFF_FFFF, 32'h1, 16'h0);
        cycle();
        chk("add_ovf_result", result_o, 32'h8000_0000);
        chk("add_ovf_flags", {28'b0, flags_o}, 32'hC);

        set(1, 0, 2'd0, 2'd0, 1, 1, 16'hFFFB, 32'h5, 32'h0, 16'h0);
        cycle();
        chk("add_imm_result", result_o, 32'h0);
        chk("add_imm_flags", {28'b0, flags_o}, 32'h3);

        set(1, 0, 2'd0, 2'd1, 0, 0, 16'h0, 32'h3, 32'h5, 16'h0);
        cycle();
        chk("sub_result", result_o, 32'hFFFF_FFFE);
        chk("sub_flags", {28'b0, flags_o}, 32'h4);

        set(1, 0, 2'd1, 2'd0, 0, 0, 16'h0, 32'h0, 32'hFFFF_FFF6, 16'h0);
        cycle();
        chk("abs_result", result_o, 32'd10);
        chk("abs_flags", {28'b0, flags_o}, 32'h0);

        set(1, 0, 2'd1, 2'd0, 0, 0, 16'h0, 32'h0, 32'h8000_0000, 16'h0);
        cycle();
        chk("abs_min_result", result_o, 32'h8000_0000);
        chk("abs_min_flags", {28'b0, flags_o}, 32'hC);

        set(1, 0, 2'd0, 2'd0, 1, 1, 16'hFFFB, 32'h5, 32'h0, 16'h0);
        cycle();
        set(1, 0, 2'd2, 2'd1, 1, 0, 16'h0010, 32'h1, 32'h0, 16'h0100);
        #3;
        check_now();
        chk("br_eq_taken", {31'b0, branch_o}, 32'h1);
        chk("br_eq_addr", {16'b0, branch_addr_o}, 32'h0110);
        advance();
        set(1, 0, 2'd2, 2'd1, 1, 0, 16'h0010, 32'h2, 32'h0, 16'h0100);
        #3;
        check_now();
        chk("br_ne_taken", {31'b0, branch_o}, 32'h0);
        advance();
        chk("br_flags_hold", {28'b0, flags_o}, 32'h3);

        set(1, 1, 2'd0, 2'd0, 0, 0, 16'h0, 32'h1, 32'h1, 16'h0);
        cycle();
        chk("stall_v_hold", {31'b0, v_o}, 32'h1);
        chk("stall_result_hold", result_o, 32'h0);
        chk("stall_flags_hold", {28'b0, flags_o}, 32'h3);

        set(0, 0, 2'd0, 2'd0, 0, 0, 16'h0, 32'h1, 32'h1, 16'h0);
        cycle();
        chk("inv_v", {31'b0, v_o}, 32'h0);
        chk("inv_flags_hold", {28'b0, flags_o}, 32'h3);

        set(0, 0, 2'd2, 2'd0, 0, 0, 16'h0, 32'h0, 32'h0, 16'h0);
        #3;
        chk("inv_branch", {31'b0, branch_o}, 32'h0);
        check_now();
        advance();

`ifdef ADDX_CARRY_EN
        set(1, 0, 2'd0, 2'd0, 0, 0, 16'h0, 32'hFFFF_FFFF, 32'h1, 16'h0);
        cycle();
        set(1, 0, 2'd0, 2'd2, 0, 0, 16'h0, 32'h1, 32'h1, 16'h0);
        cycle();
        chk("adc_result", result_o, 32'h3);
`endif

        for (int i = 0; i < 400; i++) begin
            set(($urandom_range(3) != 0), ($urandom_range(3) == 0), 2'($urandom_range(3)),
                2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                16'($urandom), $urandom, $urandom, 16'($urandom));
            if ($urandom_range(3) == 0) opr1_i = $urandom_range(1) ? 32'h8000_0000 : opr0_i;
            cycle();
        end

        set(1, 0, 2'd0, 2'd0, 0, 0, 16'h0, 32'h8000_0000, 32'h8000_0000, 16'h0);
        cycle();
        set(1, 0, 2'd0, 2'd0, 0, 0, 16'h0, 32'h1234, 32'h1, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_v", {31'b0, v_o}, 32'h0);
        chk("async_reset_result", result_o, 32'h0);
        chk("async_reset_flags", {28'b0, flags_o}, 32'h0);
        m_v = 1'b0; m_res = '0; m_flags = '0;
        @(posedge clk); #1;
        chk("reset_held_v", {31'b0, v_o}, 32'h0);
        reset = 1'b1;
        cycle();
        chk("post_reset_result", result_o, 32'h1235);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
